cic_decim_mc: RTL

Multichannel, runtime-rate CIC decimator for the DDC datapath. It is the successor to the single-channel fixed-structure CIC decimator. It takes `CHANNELS` parallel I/Q-style input lanes sharing one valid strobe and generates its own decimation tick from a programmable rate register; no external output strobe is needed. Each output is optionally rounded, and outputs are suppressed during the comb warm-up transient. It sits between the mixer/NCO stage and the compensation FIR.

---
 rtl/cic_decim_mc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cic_decim_mc.sv
// Multichannel CIC decimator with a runtime decimation rate. Integrators run at
// the input rate, combs run once per tick as a token-driven pipeline.
module cic_decim_mc #(
    parameter int DATAIN_WIDTH  = 16,
    parameter int DATAOUT_WIDTH = 16,
    parameter int CHANNELS      = 2,
    parameter int M             = 1,
    parameter int N             = 5,
    parameter int MAXRATE       = 64,
    parameter int ROUND         = 1,
    parameter int BITGROWTH     = N * $clog2(M * MAXRATE),
    localparam int W            = DATAIN_WIDTH + BITGROWTH,
    localparam int RW           = $clog2(MAXRATE) + 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              en_i,
    input  logic [CHANNELS*DATAIN_WIDTH-1:0]  data_i,
    input  logic                              valid_i,
    input  logic [RW-1:0]                     rate_i,
    input  logic                              rate_load_i,
    output logic [CHANNELS*DATAOUT_WIDTH-1:0] data_o,
    output logic                              valid_o,
    output logic [RW-1:0]                     rate_o
);

    localparam int DIN  = DATAIN_WIDTH;
    localparam int DOUT = DATAOUT_WIDTH;
    localparam int WW   = $clog2(N * M + 2);
    localparam logic [WW-1:0] WARM = WW'(N * M + 1);

    logic          accept;
    logic          load;
    logic          tick;
    logic [RW-1:0] rate_q, rate_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] warm_q, warm_d;
    logic          tick_q, tick_d;
    logic [N:0]    tok_q, tok_d;
    logic [N:0]    tvld_q, tvld_d;
    logic          vo_q, vo_d;

    always_comb begin
        accept = en_i && valid_i && !rate_load_i;
        load   = en_i && rate_load_i;
        tick   = accept && (cnt_q == rate_q - RW'(1));
        rate_d = rate_q;
        cnt_d  = cnt_q;
        warm_d = warm_q;
        tick_d = tick_q;
        tok_d  = tok_q;
        tvld_d = tvld_q;
        vo_d   = vo_q;
        if (load) begin
            if (rate_i < RW'(2))
                rate_d = RW'(2);
            else if (rate_i > RW'(MAXRATE))
                rate_d = RW'(MAXRATE);
            else
                rate_d = rate_i;
            cnt_d  = '0;
            warm_d = '0;
            tick_d = 1'b0;
            tok_d  = '0;
            tvld_d = '0;
            vo_d   = 1'b0;
        end else if (en_i) begin
            if (accept)
                cnt_d = tick ? '0 : cnt_q + RW'(1);
            tick_d = tick;
            // Each token carries whether its tick is past the comb warm-up.
            tok_d  = {tok_q[N-1:0], tick_q};
            tvld_d = {tvld_q[N-1:0], tick_q && (warm_q == WARM)};
            if (tick_q && (warm_q != WARM))
                warm_d = warm_q + WW'(1);
            vo_d = tok_q[N] && tvld_q[N];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rate_q <= RW'(MAXRATE);
            cnt_q  <= '0;
            warm_q <= '0;
            tick_q <= 1'b0;
            tok_q  <= '0;
            tvld_q <= '0;
            vo_q   <= 1'b0;
        end else begin
            rate_q <= rate_d;
            cnt_q  <= cnt_d;
            warm_q <= warm_d;
            tick_q <= tick_d;
            tok_q  <= tok_d;
            tvld_q <= tvld_d;
            vo_q   <= vo_d;
        end
    end

    assign rate_o  = rate_q;
    assign valid_o = vo_q && en_i;

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [DIN-1:0]  x;
        logic [W-1:0]    integ_q [N];
        logic [W-1:0]    integ_d [N];
        logic [W-1:0]    samp_q, samp_d;
        logic [W-1:0]    comb_q [N];
        logic [W-1:0]    comb_d [N];
        logic [W-1:0]    dly_q [N][M];
        logic [W-1:0]    dly_d [N][M];
        logic [W-1:0]    stage_in;
        logic [DOUT-1:0] out_q, out_d, scaled;

        assign x = data_i[gi*DIN +: DIN];

        always_comb begin
            integ_d  = integ_q;
            samp_d   = samp_q;
            comb_d   = comb_q;
            dly_d    = dly_q;
            out_d    = out_q;
            stage_in = '0;
            if (load) begin
                for (int i = 0; i < N; i++) begin
                    integ_d[i] = '0;
                    comb_d[i]  = '0;
                    for (int j = 0; j < M; j++)
                        dly_d[i][j] = '0;
                end
            end else if (en_i) begin
                if (accept) begin
                    integ_d[0] = integ_q[0] + {{(W-DIN){x[DIN-1]}}, x};
                    for (int i = 1; i < N; i++)
                        integ_d[i] = integ_q[i] + integ_q[i-1];
                end
                if (tick_q)
                    samp_d = integ_q[N-1];
                for (int i = 0; i < N; i++) begin
                    if (tok_q[i]) begin
                        stage_in    = (i == 0) ? samp_q : comb_q[(i == 0) ? 0 : i-1];
                        comb_d[i]   = stage_in - dly_q[i][M-1];
                        dly_d[i][0] = stage_in;
                        for (int j = 1; j < M; j++)
                            dly_d[i][j] = dly_q[i][j-1];
                    end
                end
                if (tok_q[N])
                    out_d = scaled;
            end
        end

        if (W > DOUT) begin : g_scale
            logic [DOUT-1:0] top;
            assign top = comb_q[N-1][W-1 -: DOUT];
            if (ROUND != 0) begin : g_round
                logic rbit;
                assign rbit   = comb_q[N-1][W-DOUT-1];
                // Only the most positive code can overflow when rounding up.
                assign scaled = (rbit && (top != {1'b0, {(DOUT-1){1'b1}}})) ?
                                top + DOUT'(1) : top;
            end else begin : g_trunc
                assign scaled = top;
            end
        end else begin : g_full
            assign scaled = comb_q[N-1];
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < N; i++) begin
                    integ_q[i] <= '0;
                    comb_q[i]  <= '0;
                    for (int j = 0; j < M; j++)
                        dly_q[i][j] <= '0;
                end
                samp_q <= '0;
                out_q  <= '0;
            end else begin
                integ_q <= integ_d;
                comb_q  <= comb_d;
                dly_q   <= dly_d;
                samp_q  <= samp_d;
                out_q   <= out_d;
            end
        end

        assign data_o[gi*DOUT +: DOUT] = out_q;
    end

endmodule
